// File: rtl/tap_bram_arbiter.sv
// Single-port tap BRAM arbiter between the AXI-Lite side and the FIR core.
// Build option TAP_ARB_RR_EN: round-robin core-vs-AXI policy instead of core-while-busy priority.
module tap_bram_arbiter #(
  parameter int pDATA_WIDTH   = 32,
  parameter int TAP_NUM_WIDTH = 10
) (
  input  logic                       aclk,
  input  logic                       areset,
  // AXI side
  input  logic                       in_axi_rd_req,
  input  logic                       in_axi_wr_req,
  input  logic [TAP_NUM_WIDTH-1:0]   in_axi_A,
  input  logic [pDATA_WIDTH-1:0]     in_axi_Di,
  input  logic [pDATA_WIDTH/8-1:0]   in_axi_WE,
  input  logic                       in_axi_rready,
  output logic                       out_arbit_arready,
  output logic                       out_arbit_awready,
  output logic                       out_arbit_wready,
  output logic                       out_arbit_rvalid,
  output logic [pDATA_WIDTH-1:0]     out_axi_rdata,
  // core side
  input  logic                       in_core_req,
  input  logic [TAP_NUM_WIDTH-1:0]   in_core_A,
  input  logic                       in_core_busy,
  output logic                       out_core_gnt,
  output logic                       out_core_rvalid,
  output logic [pDATA_WIDTH-1:0]     out_core_Do,
  // tap BRAM port
  output logic                       out_tap_EN,
  output logic [TAP_NUM_WIDTH-1:0]   out_tap_A,
  output logic [pDATA_WIDTH/8-1:0]   out_tap_WE,
  output logic [pDATA_WIDTH-1:0]     out_tap_Di,
  input  logic [pDATA_WIDTH-1:0]     in_tap_Do
);

  logic                     rd_inflight_q, rd_inflight_d;
  logic                     rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                     core_rvalid_q, core_rvalid_d;
  logic                     last_core_q, last_core_d;
  logic [TAP_NUM_WIDTH-1:0] a_q, a_d;
  logic [pDATA_WIDTH-1:0]   di_q, di_d;

  logic rd_ok, wr_ok, axi_ok, core_both, core_pick;
  logic core_win, wr_win, rd_win, any_win;

  // Grant decision for the current cycle
  always_comb begin
    rd_ok  = in_axi_rd_req && !rvalid_q && !rd_inflight_q;
    wr_ok  = in_axi_wr_req && !in_core_busy;
    axi_ok = rd_ok || wr_ok;
`ifdef TAP_ARB_RR_EN
    core_both = !last_core_q;
`else
    core_both = in_core_busy;
`endif
    core_pick = in_core_req && (!axi_ok || core_both);
    core_win  = !areset && core_pick;
    wr_win    = !areset && !core_pick && wr_ok;
    rd_win    = !areset && !core_pick && !wr_ok && rd_ok;
    any_win   = core_win || wr_win || rd_win;
  end

  always_comb begin
    out_tap_EN = any_win;
    out_tap_A  = core_win ? in_core_A : (any_win ? in_axi_A : a_q);
    out_tap_WE = wr_win ? in_axi_WE : '0;
    out_tap_Di = wr_win ? in_axi_Di : di_q;
  end

  always_comb begin
    a_d           = out_tap_A;
    di_d          = out_tap_Di;
    last_core_d   = any_win ? core_win : last_core_q;
    core_rvalid_d = core_win;
    rd_inflight_d = rd_win;
    // BRAM data for an AXI read appears one cycle after the grant
    rdata_d       = rd_inflight_q ? in_tap_Do : rdata_q;
    rvalid_d      = rd_inflight_q || (rvalid_q && !in_axi_rready);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_inflight_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      core_rvalid_q <= 1'b0;
      last_core_q   <= 1'b0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      core_rvalid_q <= core_rvalid_d;
      last_core_q   <= last_core_d;
    end
  end

  // Address/data hold registers only move on a grant, which reset already suppresses
  always_ff @(posedge aclk) begin
    a_q  <= a_d;
    di_q <= di_d;
  end

  assign out_arbit_arready = rd_win;
  assign out_arbit_awready = wr_win;
  assign out_arbit_wready  = wr_win;
  assign out_arbit_rvalid  = rvalid_q;
  assign out_axi_rdata     = rdata_q;
  assign out_core_gnt      = core_win;
  assign out_core_rvalid   = core_rvalid_q;
  assign out_core_Do       = in_tap_Do;

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Bench for tap_bram_arbiter: write-first BRAM model, per-cycle reference model, directed scenarios.
module tb_tap_bram_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0, rready = 1'b0;
  logic [AW-1:0] axi_a = '0;
  logic [DW-1:0] axi_di = '0;
  logic [BW-1:0] axi_we = '0;
  logic          core_req = 1'b0, busy = 1'b0;
  logic [AW-1:0] core_a = '0;
  logic          arready, awready, wready, rvalid, core_gnt, core_rv, tap_en;
  logic [DW-1:0] rdata, core_do, tap_di;
  logic [DW-1:0] tap_do = '0;
  logic [AW-1:0] tap_a;
  logic [BW-1:0] tap_we;

  int n_chk = 0;
  int n_pass = 0;

  tap_bram_arbiter #(.pDATA_WIDTH(DW), .TAP_NUM_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset),
    .in_axi_rd_req(rd_req), .in_axi_wr_req(wr_req), .in_axi_A(axi_a),
    .in_axi_Di(axi_di), .in_axi_WE(axi_we), .in_axi_rready(rready),
    .out_arbit_arready(arready), .out_arbit_awready(awready), .out_arbit_wready(wready),
    .out_arbit_rvalid(rvalid), .out_axi_rdata(rdata),
    .in_core_req(core_req), .in_core_A(core_a), .in_core_busy(busy),
    .out_core_gnt(core_gnt), .out_core_rvalid(core_rv), .out_core_Do(core_do),
    .out_tap_EN(tap_en), .out_tap_A(tap_a), .out_tap_WE(tap_we),
    .out_tap_Di(tap_di), .in_tap_Do(tap_do)
  );

  always #5 aclk = ~aclk;

  // Write-first single-port BRAM
  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [BW-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge aclk) begin
    if (tap_en) begin
      mem[tap_a] <= merge(mem[tap_a], tap_di, tap_we);
      tap_do     <= merge(mem[tap_a], tap_di, tap_we);
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model state, advanced once per cycle
  logic          m_rvalid = 0, m_pend = 0, m_last_core = 0, m_core_rv = 0;
  logic [DW-1:0] m_rdata = '0, m_pend_val = '0, m_core_val = '0, m_di = '0;
  logic [AW-1:0] m_a = '0;
  logic          m_a_known = 0, m_di_known = 0;

  always @(negedge aclk) begin : mon
    logic rd_ok, wr_ok, ax_ok, core_first, cw, ww, rw, anyg;
    cw = 0; ww = 0; rw = 0;
    if (!areset) begin
      rd_ok = rd_req && !m_rvalid && !m_pend;
      wr_ok = wr_req && !busy;
      ax_ok = rd_ok || wr_ok;
`ifdef TAP_ARB_RR_EN
      core_first = !m_last_core;
`else
      core_first = busy;
`endif
      if (core_req && (!ax_ok || core_first)) cw = 1;
      else if (wr_ok) ww = 1;
      else if (rd_ok) rw = 1;
    end
    anyg = cw || ww || rw;
    chk("arready", arready, rw);
    chk("awready", awready, ww);
    chk("wready", wready, ww);
    chk("core_gnt", core_gnt, cw);
    chk("tap_en", tap_en, anyg);
    chk("tap_we", tap_we, ww ? axi_we : '0);
    if (anyg) chk("tap_a", tap_a, cw ? core_a : axi_a);
    else if (m_a_known) chk("tap_a_hold", tap_a, m_a);
    if (ww) chk("tap_di", tap_di, axi_di);
    else if (m_di_known) chk("tap_di_hold", tap_di, m_di);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
    chk("core_rvalid", core_rv, m_core_rv);
    if (m_core_rv) chk("core_do", core_do, m_core_val);

    if (areset) begin
      m_rvalid = 0; m_pend = 0; m_rdata = '0; m_last_core = 0; m_core_rv = 0;
    end else begin
      m_core_rv = cw;
      if (cw) m_core_val = mem[core_a];
      if (anyg) begin
        m_last_core = cw;
        m_a = cw ? core_a : axi_a;
        m_a_known = 1;
      end
      if (ww) begin m_di = axi_di; m_di_known = 1; end
      if (m_pend) begin m_rdata = m_pend_val; m_rvalid = 1; m_pend = 0; end
      else if (m_rvalid && rready) m_rvalid = 0;
      if (rw) begin m_pend = 1; m_pend_val = mem[axi_a]; end
    end
  end

  // Stimulus side: sampled outputs of the cycle just finished
  logic          g_ar, g_aw, g_core, g_rv, g_crv;
  logic [DW-1:0] g_rdata, g_cdo;
  logic          keep_rd = 0, keep_core = 0;

  task automatic step();
    @(negedge aclk);
    g_ar = arready; g_aw = awready; g_core = core_gnt; g_rv = rvalid;
    g_rdata = rdata; g_crv = core_rv; g_cdo = core_do;
    @(posedge aclk);
    #1;
    if (g_ar && !keep_rd) rd_req = 0;
    if (g_aw) wr_req = 0;
    if (g_core && !keep_core) core_req = 0;
  endtask

  task automatic wait_ar(string nm);
    logic got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (g_ar) begin got = 1; break; end
    end
    chk(nm, got, 1'b1);
  endtask

  initial begin
    int cnt_ar, cnt_core, cnt_g;
    logic seen;
    for (int i = 0; i < (1<<AW); i++) mem[i] <= {16'hA5A5, 6'd0, i[9:0]};
    mem[5] <= 32'h0000_1234;

    // Reset with all requests asserted: nothing may be granted
    step(); step();
    rd_req = 1; wr_req = 1; core_req = 1; axi_a = 10'd2; axi_di = 32'h5555_5555; axi_we = '1; core_a = 10'd1;
    cnt_g = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt_g += int'(g_ar) + int'(g_aw) + int'(g_core); end
    chk("reset_no_grant", cnt_g, 0);
    chk("reset_rvalid", g_rv, 1'b0);
    chk("reset_rdata", g_rdata, 32'h0);
    chk("reset_core_rvalid", g_crv, 1'b0);
    rd_req = 0; wr_req = 0; core_req = 0; areset = 0;
    step();

    // AXI read of address 5 with rready low for three cycles
    rd_req = 1; axi_a = 10'd5; rready = 0;
    wait_ar("r037_grant");
    step(); chk("r037_rv_t1", g_rv, 1'b0);
    step(); chk("r037_rv_t2", g_rv, 1'b1);
    step(); chk("r037_rv_t3", g_rv, 1'b1);
    step(); chk("r037_rv_t4", g_rv, 1'b1);
    rready = 1;
    step(); chk("r037_rv_t5", g_rv, 1'b1); chk("r037_rdata", g_rdata, 32'h0000_1234);
    step(); chk("r037_rv_done", g_rv, 1'b0);

    // AXI write stalled by core busy, then read back
    busy = 1; wr_req = 1; axi_a = 10'd3; axi_di = 32'h0000_DEAD; axi_we = 4'hF;
    cnt_g = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt_g += int'(g_aw); end
    chk("r038_no_aw_busy", cnt_g, 0);
    busy = 0;
    step(); chk("r038_aw_on_idle", g_aw, 1'b1);
    rd_req = 1;
    step(); chk("r038_rd_grant", g_ar, 1'b1);
    step(); step(); chk("r038_rv", g_rv, 1'b1); chk("r038_rdata", g_rdata, 32'h0000_DEAD);

    // Simultaneous read and write: write first, partial byte enables
    step();
    wr_req = 1; rd_req = 1; axi_a = 10'd7; axi_di = 32'hBEEF_0001; axi_we = 4'b0011;
    step(); chk("r040_wr_first", {g_aw, g_ar}, 2'b10);
    step(); chk("r040_rd_next", {g_aw, g_ar}, 2'b01);
    step(); step(); chk("r040_rdata", g_rdata, 32'hA5A5_0001);
    step();

    // Core and AXI read both requesting continuously while busy
    busy = 1; core_req = 1; core_a = 10'd11; rd_req = 1; axi_a = 10'd9; rready = 1;
    keep_rd = 1; keep_core = 1;
    cnt_ar = 0; cnt_core = 0;
    for (int i = 0; i < 12; i++) begin step(); cnt_ar += int'(g_ar); cnt_core += int'(g_core); end
`ifdef TAP_ARB_RR_EN
    chk("r039_rr_ar", cnt_ar, 4);
    chk("r039_rr_core", cnt_core, 8);
`else
    chk("r039_fix_ar", cnt_ar, 0);
    chk("r039_fix_core", cnt_core, 12);
`endif
    keep_rd = 0; keep_core = 0; rd_req = 0; core_req = 0;
    step(); step(); step();
    busy = 0;

    // Core served when idle; loses to AXI when both ask and core is idle
    core_req = 1; core_a = 10'd20;
    step(); chk("r036_core_alone", g_core, 1'b1);
    core_req = 1; core_a = 10'd22; rd_req = 1; axi_a = 10'd21;
    step(); chk("r036_axi_wins", {g_ar, g_core}, 2'b10);
    step(); chk("r036_core_next", g_core, 1'b1);
    step(); chk("r036_core_rv", g_crv, 1'b1); chk("r036_core_do", g_cdo, 32'hA5A5_0016);
    step(); step();

    // Reset in the cycle after an AXI read grant
    rd_req = 1; axi_a = 10'd5; rready = 0;
    wait_ar("r041_grant");
    areset = 1;
    step();
    areset = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin step(); seen |= g_rv; end
    chk("r041_no_rvalid", seen, 1'b0);
    chk("r041_rdata_zero", g_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
